retire_monitor: RTL and testbench
=================================

// Module: retire_monitor
// PURPOSE
//  Watches the retire (writeback) stage of the forwarding pipeline. Counts cycles, retired
//  instructions and bubbles (o_insn_vld low), and detects the end-of-program idiom: the
//  self-loop jal x0,0 (32'h0000006f) retiring repeatedly. On detection it freezes its counters
//  and exposes them through a registered read port, which feeds the LSU debug window and the bench.
// PARAMETERS
//  HALT_REPEAT  4         consecutive valid retires of 32'h0000006f that declare halt (>=1)
//  CNT_W        32        width of each event counter (<=32; zero-extended on read)
// PORTS
//  i_clk        in   1      clock; all logic on rising edge
//  i_rst        in   1      reset, synchronous, active-high
//  i_insn_vld   in   1      retire-stage instruction valid (0 = bubble/flush)
//  i_pc_debug   in   32     PC of retiring instruction (valid when i_insn_vld=1)
//  i_instr      in   32     instruction word retiring (valid when i_insn_vld=1)
//  i_clr        in   1      synchronous counter clear + rearm
//  i_rd_addr    in   3      read-port register select
//  o_rd_data    out  32     registered read data, 1-cycle latency
//  o_running    out  1      state == RUN
//  o_halted     out  1      state == HALTED
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, all counters=0, halt_pc=0, rep_cnt=0, o_rd_data=0, o_running=0, o_halted=0.
//  States:
//   IDLE   : counters held. First cycle with i_insn_vld=1 -> RUN; that cycle already counts
//            (cycle+1, retire+1, and halt-match logic applies).
//   RUN    : every cycle cycle_cnt+1; i_insn_vld=1 -> retire_cnt+1, else bubble_cnt+1.
//            Halt match: valid & i_instr==32'h0000006f -> rep_cnt+1; valid & other instr ->
//            rep_cnt=0; bubble -> rep_cnt unchanged. When rep_cnt would reach HALT_REPEAT:
//            that cycle is still counted, halt_pc<=i_pc_debug, next state HALTED.
//   HALTED : all counters and halt_pc frozen; inputs ignored except i_clr/i_rst.
//  Priority: i_rst > i_clr > normal update. i_clr (any state): counters, rep_cnt, halt_pc = 0,
//   state -> IDLE; the clr cycle itself is not counted. i_clr mid-RUN is legal.
//  Counters saturate at all-ones (no wrap); rep_cnt saturates at HALT_REPEAT.
//  HALT_REPEAT=1: the first valid halt retire halts, including directly from IDLE.
//  Outputs o_running/o_halted are decoded from the state register (no combinational path
//   from inputs).
//  Read map (o_rd_data <= f(i_rd_addr) each cycle; reflects counter values before this edge):
//   0 cycle_cnt  1 retire_cnt  2 bubble_cnt  3 halt_pc
//   4 {30'b0, o_halted, o_running}  5..7 32'h0
//  Invariant in RUN/HALTED: cycle_cnt == retire_cnt + bubble_cnt (until saturation).
// TESTING
//  1 Reset then 3 bubbles, 5 valid non-halt retires, 2 bubbles -> state RUN;
//    cycle=7, retire=5, bubble=2; the leading 3 bubbles are not counted (IDLE).
//  2 HALT_REPEAT=4, retire 0x6f x4 at PC 0x40, separated by 1 bubble each ->
//    o_halted=1 after the 4th; halt_pc=0x40; later retires leave counters unchanged.
//  3 Retire 0x6f x3, then addi 0x00100093, then 0x6f x4 -> halt only after the final 4;
//    retire=8.
//  4 i_clr asserted in the same cycle as the halting retire -> IDLE;
//    all counters=0, o_halted=0, o_running=0.
//  5 CNT_W=4: 20 valid retires -> retire_cnt=4'hF (saturated); read addr 1 -> 32'h0000000F.
//  6 Read sweep addr 0..7 after test 2 -> data appears 1 cycle after each address;
//    addr 4 -> 32'h2; addr 5..7 -> 0. i_rst pulse mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/retire_monitor_if.sv
// Retire-stage observation bundle between the writeback stage (master) and the monitor (slave).
// Latency: none, wires only; read data is registered inside the monitor.
// Backpressure: none; the retire stream is observe-only and the monitor cannot stall it.
interface retire_monitor_if;
    logic        i_insn_vld;
    logic [31:0] i_pc_debug;
    logic [31:0] i_instr;
    logic        i_clr;
    logic [2:0]  i_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_running;
    logic        o_halted;

    modport master (
        output i_insn_vld, i_pc_debug, i_instr, i_clr, i_rd_addr,
        input  o_rd_data, o_running, o_halted
    );

    modport slave (
        input  i_insn_vld, i_pc_debug, i_instr, i_clr, i_rd_addr,
        output o_rd_data, o_running, o_halted
    );
endinterface

// File: rtl/retire_monitor.sv
// Counts cycles/retires/bubbles at writeback and freezes them when the jal x0,0 self-loop retires HALT_REPEAT times.
// Latency: read port is registered, 1 cycle from i_rd_addr to o_rd_data; state flags are decoded from the state register.
// Backpressure: none; observe-only, so every retire cycle is accepted unconditionally.
module retire_monitor #(
    parameter int HALT_REPEAT = 4,
    parameter int CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    retire_monitor_if.slave   mon
);

    localparam int                REP_W     = $clog2(HALT_REPEAT + 1);
    localparam logic [31:0]       HALT_INSN = 32'h0000006f;
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(HALT_REPEAT - 1);
    localparam logic [REP_W-1:0]  REP_FULL  = REP_W'(HALT_REPEAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [CNT_W-1:0]  bub_q, bub_d;
    logic [31:0]       halt_pc_q, halt_pc_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [31:0]       rd_dat_q;
    logic              active;
    logic              halt_insn;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state and counter update; clear beats normal counting, and the clear cycle itself is not counted.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        bub_d     = bub_q;
        halt_pc_d = halt_pc_q;
        rep_d     = rep_q;
        active    = 1'b0;
        halt_insn = mon.i_insn_vld && (mon.i_instr == HALT_INSN);

        if (mon.i_clr) begin
            state_d   = ST_IDLE;
            cyc_d     = '0;
            ret_d     = '0;
            bub_d     = '0;
            halt_pc_d = '0;
            rep_d     = '0;
        end else begin
            // The first valid retire out of IDLE is already counted as a RUN cycle.
            active = (state_q == ST_RUN) || ((state_q == ST_IDLE) && mon.i_insn_vld);
            if (active) begin
                state_d = ST_RUN;
                cyc_d   = sat_inc(cyc_q);
                if (mon.i_insn_vld) begin
                    ret_d = sat_inc(ret_q);
                end else begin
                    bub_d = sat_inc(bub_q);
                end
                // Bubbles leave the self-loop streak alone; any other valid instruction breaks it.
                if (halt_insn) begin
                    if (rep_q == REP_LAST) begin
                        rep_d     = REP_FULL;
                        halt_pc_d = mon.i_pc_debug;
                        state_d   = ST_HALTED;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end else if (mon.i_insn_vld) begin
                    rep_d = '0;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, streak and halt PC registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cyc_q     <= '0;
            ret_q     <= '0;
            bub_q     <= '0;
            halt_pc_q <= '0;
            rep_q     <= '0;
        end else begin
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
            bub_q     <= bub_d;
            halt_pc_q <= halt_pc_d;
            rep_q     <= rep_d;
        end
    end

    // Registered read port showing the values held before this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_dat_q <= '0;
        end else begin
            case (mon.i_rd_addr)
                3'd0:    rd_dat_q <= 32'(cyc_q);
                3'd1:    rd_dat_q <= 32'(ret_q);
                3'd2:    rd_dat_q <= 32'(bub_q);
                3'd3:    rd_dat_q <= halt_pc_q;
                3'd4:    rd_dat_q <= {30'b0, state_q == ST_HALTED, state_q == ST_RUN};
                default: rd_dat_q <= 32'h0;
            endcase
        end
    end

    assign mon.o_rd_data = rd_dat_q;
    assign mon.o_running = (state_q == ST_RUN);
    assign mon.o_halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: two instances (default and HALT_REPEAT=1/CNT_W=4) driven by identical stimulus.
// Latency: every cycle compares read data and state flags against a per-instance reference model.
// Backpressure: none on the monitor; all stimulus is fixed-length, so the run always terminates.
module tb_retire_monitor;

    localparam logic [31:0] JAL_SELF = 32'h0000006f;
    localparam logic [31:0] ADDI     = 32'h00100093;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    retire_monitor_if if0();
    retire_monitor_if if1();

    retire_monitor #(.HALT_REPEAT(4), .CNT_W(32)) dut0 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .mon   (if0)
    );

    retire_monitor #(.HALT_REPEAT(1), .CNT_W(4)) dut1 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .mon   (if1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-instance tallies, driven by the counting and halting rules.
    logic [31:0] m_cyc [2];
    logic [31:0] m_ret [2];
    logic [31:0] m_bub [2];
    logic [31:0] m_hpc [2];
    bit          m_run [2];
    bit          m_halt[2];
    int          m_streak[2];
    int          m_need[2] = '{4, 1};
    logic [31:0] m_max [2] = '{32'hFFFF_FFFF, 32'h0000_000F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [2:0] a);
        case (a)
            3'd0:    return m_cyc[d];
            3'd1:    return m_ret[d];
            3'd2:    return m_bub[d];
            3'd3:    return m_hpc[d];
            3'd4:    return {30'b0, m_halt[d], m_run[d]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input int d, input bit rst, input bit clr, input bit vld,
                              input logic [31:0] instr, input logic [31:0] pc);
        if (rst || clr) begin
            m_cyc[d] = 0; m_ret[d] = 0; m_bub[d] = 0; m_hpc[d] = 0;
            m_run[d] = 0; m_halt[d] = 0; m_streak[d] = 0;
        end else if (!m_halt[d] && (m_run[d] || vld)) begin
            m_run[d] = 1;
            if (m_cyc[d] < m_max[d]) m_cyc[d] = m_cyc[d] + 1;
            if (vld) begin
                if (m_ret[d] < m_max[d]) m_ret[d] = m_ret[d] + 1;
            end else begin
                if (m_bub[d] < m_max[d]) m_bub[d] = m_bub[d] + 1;
            end
            if (vld && instr == JAL_SELF) begin
                m_streak[d]++;
                if (m_streak[d] >= m_need[d]) begin
                    m_halt[d] = 1;
                    m_run[d]  = 0;
                    m_hpc[d]  = pc;
                end
            end else if (vld) begin
                m_streak[d] = 0;
            end
        end
    endtask

    function automatic logic [31:0] nonhalt();
        return $urandom() | 32'h0000_1000;
    endfunction

    // One clock: drive both instances, advance the model, then compare everything at edge+1.
    task automatic step(input bit vld, input logic [31:0] instr, input logic [31:0] pc,
                        input bit clr, input logic [2:0] addr, input bit rst);
        logic [31:0] exp_rd[2];
        i_rst          = rst;
        if0.i_insn_vld = vld;  if1.i_insn_vld = vld;
        if0.i_instr    = instr; if1.i_instr   = instr;
        if0.i_pc_debug = pc;   if1.i_pc_debug = pc;
        if0.i_clr      = clr;  if1.i_clr      = clr;
        if0.i_rd_addr  = addr; if1.i_rd_addr  = addr;
        for (int d = 0; d < 2; d++) begin
            exp_rd[d] = rst ? 32'h0 : model_read(d, addr);
            model_step(d, rst, clr, vld, instr, pc);
        end
        @(posedge i_clk);
        #1;
        check("rd0",   if0.o_rd_data, exp_rd[0]);
        check("run0",  32'(if0.o_running), 32'(m_run[0]));
        check("halt0", 32'(if0.o_halted),  32'(m_halt[0]));
        check("rd1",   if1.o_rd_data, exp_rd[1]);
        check("run1",  32'(if1.o_running), 32'(m_run[1]));
        check("halt1", 32'(if1.o_halted),  32'(m_halt[1]));
    endtask

    task automatic bub(input logic [2:0] a);
        step(1'b0, ADDI, 32'h0, 1'b0, a, 1'b0);
    endtask

    task automatic rtr(input logic [31:0] instr, input logic [31:0] pc);
        step(1'b1, instr, pc, 1'b0, 3'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic clr_cyc();
        step(1'b0, ADDI, 32'h0, 1'b1, 3'd0, 1'b0);
    endtask

    logic [31:0] sweep_exp[8];

    initial begin
        sweep_exp = '{32'd7, 32'd4, 32'd3, 32'h40, 32'h2, 32'h0, 32'h0, 32'h0};

        // Reset state.
        step(1'b0, ADDI, 32'h0, 1'b0, 3'd0, 1'b1);
        step(1'b0, ADDI, 32'h0, 1'b0, 3'd4, 1'b1);
        check("rst_rd",   if0.o_rd_data, 32'h0);
        check("rst_run",  32'(if0.o_running), 32'h0);
        check("rst_halt", 32'(if0.o_halted), 32'h0);

        // Leading bubbles in IDLE are not counted; then 5 retires, 2 bubbles.
        for (int i = 0; i < 3; i++) bub(3'd0);
        check("t1_idle", 32'(if0.o_running), 32'h0);
        for (int i = 0; i < 5; i++) rtr(nonhalt(), 32'h1000 + 32'(i * 4));
        bub(3'd0);
        bub(3'd0);
        check("t1_run", 32'(if0.o_running), 32'h1);
        bub(3'd2);
        check("t1_bub", if0.o_rd_data, 32'd2);
        bub(3'd1);
        check("t1_ret", if0.o_rd_data, 32'd5);
        // Two read-cycle bubbles in RUN were added on top of the 7 cycles.
        bub(3'd0);
        check("t1_cyc", if0.o_rd_data, 32'd9);

        // Self-loop x4 separated by bubbles; HALT_REPEAT=1 instance halts on the first one.
        clr_cyc();
        rtr(JAL_SELF, 32'h40);
        check("t2_h1_first", 32'(if1.o_halted), 32'h1);
        bub(3'd0);
        rtr(JAL_SELF, 32'h40);
        bub(3'd0);
        rtr(JAL_SELF, 32'h40);
        check("t2_not_yet", 32'(if0.o_halted), 32'h0);
        bub(3'd0);
        rtr(JAL_SELF, 32'h40);
        check("t2_halted", 32'(if0.o_halted), 32'h1);
        for (int i = 0; i < 3; i++) rtr(($urandom_range(0, 1) == 1) ? JAL_SELF : nonhalt(), $urandom());
        // Read sweep while halted; retires offered alongside must be ignored.
        for (int a = 0; a < 8; a++) begin
            step(1'b1, nonhalt(), $urandom(), 1'b0, 3'(a), 1'b0);
            check($sformatf("t6_sweep%0d", a), if0.o_rd_data, sweep_exp[a]);
        end
        bub(3'd1);
        check("t2_h1_ret", if1.o_rd_data, 32'd1);

        // Streak broken by addi: halt only after the final four.
        clr_cyc();
        for (int i = 0; i < 3; i++) rtr(JAL_SELF, 32'h100 + 32'(i * 4));
        rtr(ADDI, 32'h10c);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_pre%0d", i), 32'(if0.o_halted), 32'h0);
            rtr(JAL_SELF, 32'h110 + 32'(i * 4));
        end
        check("t3_halted", 32'(if0.o_halted), 32'h1);
        bub(3'd1);
        check("t3_ret", if0.o_rd_data, 32'd8);
        bub(3'd3);
        check("t3_hpc", if0.o_rd_data, 32'h11c);

        // Clear wins over the halting retire in the same cycle.
        clr_cyc();
        for (int i = 0; i < 3; i++) rtr(JAL_SELF, 32'h200);
        step(1'b1, JAL_SELF, 32'h200, 1'b1, 3'd0, 1'b0);
        check("t4_run",   32'(if0.o_running), 32'h0);
        check("t4_halt",  32'(if0.o_halted), 32'h0);
        check("t4_halt1", 32'(if1.o_halted), 32'h0);
        bub(3'd0);
        check("t4_cyc", if0.o_rd_data, 32'h0);
        bub(3'd1);
        check("t4_ret", if0.o_rd_data, 32'h0);

        // Saturation of the narrow counter.
        clr_cyc();
        for (int i = 0; i < 20; i++) rtr(nonhalt(), 32'h300 + 32'(i * 4));
        bub(3'd1);
        check("t5_sat",  if1.o_rd_data, 32'h0000000F);
        check("t5_wide", if0.o_rd_data, 32'd20);

        // Reset mid-RUN.
        for (int i = 0; i < 3; i++) rtr(nonhalt(), $urandom());
        step(1'b1, nonhalt(), 32'h0, 1'b0, 3'd1, 1'b1);
        check("t6_rst_rd",   if0.o_rd_data, 32'h0);
        check("t6_rst_run",  32'(if0.o_running), 32'h0);
        check("t6_rst_halt", 32'(if1.o_halted), 32'h0);

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 4) < 2) ? JAL_SELF : nonhalt(),
                 $urandom(),
                 ($urandom_range(0, 49) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
